// File: rtl/unified_mem_arbiter_if.sv
// Bundles the fetch port, data port and memory-side signals of the unified memory arbiter.
// The slave modport is the arbiter's view; the master modport is the pipeline/memory side.
interface unified_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  if_req_i;
    logic [ADDR_WIDTH-1:0] if_addr_i;
    logic [DATA_WIDTH-1:0] if_rdata_o;
    logic                  if_ack_o;
    logic                  if_stall_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [DATA_WIDTH-1:0] d_rdata_o;
    logic                  d_ack_o;
    logic                  d_stall_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i,
        input  mem_rdata_i,
        output if_rdata_o, if_ack_o, if_stall_o,
        output d_rdata_o, d_ack_o, d_stall_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );

    modport master (
        output if_req_i, if_addr_i,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i,
        output mem_rdata_i,
        input  if_rdata_o, if_ack_o, if_stall_o,
        input  d_rdata_o, d_ack_o, d_stall_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_wdata_o
    );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port memory between instruction fetch and load/store, one access at a time.
// Data port has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data grants.
module unified_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int MEM_LATENCY  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    unified_mem_arbiter_if.slave     bus,
    output logic                     busy_o
);
    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam int LW = $clog2(MEM_LATENCY + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [LW-1:0] LAT_MAX    = LW'(MEM_LATENCY);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE_IF,
        ISSUE_D,
        WAIT_IF,
        WAIT_D
    } state_e;

    state_e                state_q, state_d;
    logic [SW-1:0]         starve_q, starve_d;
    logic [LW-1:0]         lat_q, lat_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
    logic                  if_ack_q, if_ack_d;
    logic                  d_ack_q, d_ack_d;
    logic                  if_pend, d_pend;

    // A port being acknowledged this cycle has its request treated as already complete.
    assign if_pend = bus.if_req_i & ~if_ack_q;
    assign d_pend  = bus.d_req_i & ~d_ack_q;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        lat_d      = lat_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_ack_d   = 1'b0;
        d_ack_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!if_pend) begin
                    starve_d = '0;
                end
                if (if_pend && (!d_pend || starve_q == STARVE_MAX)) begin
                    state_d  = ISSUE_IF;
                    addr_d   = bus.if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = '0;
                    starve_d = '0;
                end else if (d_pend) begin
                    state_d = ISSUE_D;
                    addr_d  = bus.d_addr_i;
                    we_d    = bus.d_we_i;
                    wdata_d = bus.d_wdata_i;
                    if (if_pend && starve_q != STARVE_MAX) begin
                        starve_d = starve_q + SW'(1);
                    end
                end
            end
            ISSUE_IF: begin
                state_d = WAIT_IF;
                lat_d   = LW'(1);
            end
            ISSUE_D: begin
                state_d = WAIT_D;
                lat_d   = LW'(1);
            end
            WAIT_IF: begin
                if (lat_q == LAT_MAX) begin
                    state_d    = IDLE;
                    lat_d      = '0;
                    if_rdata_d = bus.mem_rdata_i;
                    if_ack_d   = 1'b1;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            WAIT_D: begin
                if (lat_q == LAT_MAX) begin
                    state_d = IDLE;
                    lat_d   = '0;
                    if (!we_q) begin
                        d_rdata_d = bus.mem_rdata_i;
                    end
                    d_ack_d = 1'b1;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            starve_q   <= '0;
            lat_q      <= '0;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_ack_q   <= 1'b0;
            d_ack_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            lat_q      <= lat_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_ack_q   <= if_ack_d;
            d_ack_q    <= d_ack_d;
        end
    end

    assign bus.mem_en_o    = (state_q == ISSUE_IF) || (state_q == ISSUE_D);
    assign bus.mem_we_o    = we_q & bus.mem_en_o;
    assign bus.mem_addr_o  = addr_q;
    assign bus.mem_wdata_o = wdata_q;
    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
    assign bus.d_rdata_o   = d_rdata_q;
    assign bus.d_ack_o     = d_ack_q;
    assign bus.d_stall_o   = bus.d_req_i & ~d_ack_q;
    assign busy_o          = (state_q != IDLE);
endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Scoreboard bench: two arbiter configurations driven by random fetch/data traffic, checked
// against a transaction-level arbitration, latency and memory model.
module tb_unified_mem_arbiter;
    localparam int NOPS = 60;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic clk = 1'b0;
    int   cyc = 0;
    int   errs = 0;
    int   chks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] hashf(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    // Contents of memory locations never written by the bench.
    function automatic logic [31:0] initval(input logic [31:0] a);
        return (a == 32'h0000_0040) ? 32'hDEAD_BEEF : hashf(a);
    endfunction

    function automatic void chk(input int c, input string nm, input logic [31:0] act,
                                input logic [31:0] exp);
        chks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL cfg%0d %s: got %h, expected %h (cycle %0d)", c, nm, act, exp, cyc);
        end
    endfunction

    function automatic void fail_evt(input int c, input string nm);
        chks++;
        errs++;
        $display("FAIL cfg%0d %s: got no ack, expected ack within bound (cycle %0d)", c, nm, cyc);
    endfunction

    for (genvar g = 0; g < 2; g++) begin : cfg
        localparam int L  = (g == 0) ? 1 : 3;
        localparam int SL = (g == 0) ? 4 : 0;

        logic rst    = 1'b1;
        logic busy;
        logic done_f = 1'b0;

        unified_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

        unified_mem_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .MEM_LATENCY (L),
            .STARVE_LIMIT(SL)
        ) dut (
            .clk   (clk),
            .reset (rst),
            .bus   (bus.slave),
            .busy_o(busy)
        );

        txn_t        if_q[$];
        txn_t        d_q[$];
        logic [31:0] refmem [logic [31:0]];
        logic [31:0] mem_arr[logic [31:0]];
        int          pd_due = -1;
        logic [31:0] pd_data = '0;
        int          if_gn = 0, d_gn = 0;
        int          if_due = -1, d_due = -1, win = -1, streak = 0;
        logic        busy_prev = 1'b0, ifp_prev = 1'b0, dp_prev = 1'b0, rst_prev = 1'b0;
        logic [31:0] if_rd_m = '0, d_rd_m = '0;
        logic        m_en, m_gif, m_bexp, m_eif, m_ed;
        txn_t        m_t;

        // Memory macro: read data valid only in the cycle exactly L after the strobe.
        always @(negedge clk) begin
            if (bus.mem_en_o === 1'b1) begin
                if (bus.mem_we_o) begin
                    mem_arr[bus.mem_addr_o] = bus.mem_wdata_o;
                end else begin
                    pd_due  = cyc + L;
                    pd_data = mem_arr.exists(bus.mem_addr_o) ? mem_arr[bus.mem_addr_o]
                                                             : initval(bus.mem_addr_o);
                end
            end
            bus.mem_rdata_i = (pd_due == cyc) ? pd_data : $urandom;
        end

        // Monitor: the grant in cycle c follows from the requests pending in cycle c-1.
        always @(negedge clk) begin
            m_en = !busy_prev && (ifp_prev || dp_prev);
            chk(g, "mem_en", bus.mem_en_o, m_en);
            if (rst_prev) begin
                chk(g, "rst_mem_addr", bus.mem_addr_o, 32'h0);
                chk(g, "rst_mem_wdata", bus.mem_wdata_o, 32'h0);
                chk(g, "rst_mem_we", bus.mem_we_o, 0);
            end
            if (bus.mem_en_o === 1'b1) begin
                if (!ifp_prev) streak = 0;
                m_gif = ifp_prev && (!dp_prev || streak == SL);
                m_t   = '0;
                if (m_gif) begin
                    streak = 0;
                    if (if_q.size() > 0) m_t = if_q[0];
                    else fail_evt(g, "if_grant_without_request");
                    if_due = cyc + L + 1;
                    if_gn++;
                end else begin
                    if (ifp_prev && streak < SL) streak++;
                    if (d_q.size() > 0) m_t = d_q[0];
                    else fail_evt(g, "d_grant_without_request");
                    d_due = cyc + L + 1;
                    d_gn++;
                end
                win = cyc;
                chk(g, m_gif ? "if_grant_addr" : "d_grant_addr", bus.mem_addr_o, m_t.addr);
                chk(g, "grant_we", bus.mem_we_o, m_t.we);
                if (m_t.we) chk(g, "grant_wdata", bus.mem_wdata_o, m_t.wdata);
            end else if (!busy_prev && !ifp_prev) begin
                streak = 0;
            end

            m_bexp = (win >= 0) && (cyc >= win) && (cyc <= win + L);
            chk(g, "busy", busy, m_bexp);
            m_eif = (if_due == cyc);
            m_ed  = (d_due == cyc);
            chk(g, "if_ack", bus.if_ack_o, m_eif);
            chk(g, "d_ack", bus.d_ack_o, m_ed);
            if (m_eif && if_q.size() > 0) begin
                m_t     = if_q.pop_front();
                if_rd_m = m_t.rdata;
            end
            if (m_ed && d_q.size() > 0) begin
                m_t = d_q.pop_front();
                if (!m_t.we) d_rd_m = m_t.rdata;
            end
            chk(g, "if_rdata", bus.if_rdata_o, if_rd_m);
            chk(g, "d_rdata", bus.d_rdata_o, d_rd_m);
            chk(g, "if_stall", bus.if_stall_o, bus.if_req_i && !m_eif);
            chk(g, "d_stall", bus.d_stall_o, bus.d_req_i && !m_ed);

            ifp_prev  = bus.if_req_i && !m_eif;
            dp_prev   = bus.d_req_i && !m_ed;
            busy_prev = m_bexp;
            if (rst) begin
                busy_prev = 1'b0;
                ifp_prev  = 1'b0;
                dp_prev   = 1'b0;
                streak    = 0;
                if_due    = -1;
                d_due     = -1;
                win       = -1;
                if_rd_m   = '0;
                d_rd_m    = '0;
            end
            rst_prev = rst;
        end

        initial begin
            bus.if_req_i  = 1'b0;
            bus.if_addr_i = '0;
            bus.d_req_i   = 1'b0;
            bus.d_we_i    = 1'b0;
            bus.d_addr_i  = '0;
            bus.d_wdata_i = '0;
            rst = 1'b1;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;

            fork
                begin : ifdrv
                    logic [31:0] a;
                    int          snap, tmo;
                    bit          fin;
                    repeat (4) begin @(posedge clk); #1; end
                    for (int n = 0; n < NOPS; n++) begin
                        if (n >= 16) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        a = 32'h1000_0000 | (32'($urandom_range(0, 1023)) << 2);
                        if_q.push_back('{addr: a, we: 1'b0, wdata: 32'h0, rdata: initval(a)});
                        bus.if_addr_i = a;
                        bus.if_req_i  = 1'b1;
                        snap = if_gn;
                        tmo  = 0;
                        fin  = 0;
                        while (!fin) begin
                            @(posedge clk); #1;
                            tmo++;
                            if (bus.if_ack_o) begin
                                fin = 1;
                            end else if (tmo > 100) begin
                                fail_evt(g, "if_timeout");
                                fin = 1;
                            end else if (if_gn != snap) begin
                                bus.if_addr_i = $urandom;
                                if ($urandom_range(0, 3) == 0) bus.if_req_i = 1'b0;
                            end
                        end
                        bus.if_req_i = 1'b0;
                    end
                end
                begin : ddrv
                    logic [31:0] a, wd, rd;
                    logic        we;
                    int          snap, tmo;
                    bit          fin;
                    for (int n = 0; n < NOPS; n++) begin
                        if (n >= 16) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                        if (n == 0) begin
                            a = 32'h0000_0040; we = 1'b0; wd = 32'h0;
                        end else if (n == 1) begin
                            a = 32'h0000_0080; we = 1'b1; wd = 32'h1234_5678;
                        end else begin
                            a  = 32'h2000_0000 | (32'($urandom_range(0, 63)) << 2);
                            we = 1'($urandom_range(0, 1));
                            wd = $urandom;
                        end
                        if (we) begin
                            refmem[a] = wd;
                            rd = 32'h0;
                        end else begin
                            rd = refmem.exists(a) ? refmem[a] : initval(a);
                        end
                        d_q.push_back('{addr: a, we: we, wdata: wd, rdata: rd});
                        bus.d_addr_i  = a;
                        bus.d_we_i    = we;
                        bus.d_wdata_i = wd;
                        bus.d_req_i   = 1'b1;
                        snap = d_gn;
                        tmo  = 0;
                        fin  = 0;
                        while (!fin) begin
                            @(posedge clk); #1;
                            tmo++;
                            if (bus.d_ack_o) begin
                                fin = 1;
                            end else if (tmo > 100) begin
                                fail_evt(g, "d_timeout");
                                fin = 1;
                            end else if (d_gn != snap) begin
                                bus.d_addr_i  = $urandom;
                                bus.d_wdata_i = $urandom;
                                bus.d_we_i    = 1'($urandom_range(0, 1));
                                if ($urandom_range(0, 3) == 0) bus.d_req_i = 1'b0;
                            end
                        end
                        bus.d_req_i = 1'b0;
                    end
                end
            join

            // Reset during the first wait cycle of a load abandons it without an ack.
            begin : rst_test
                int snap, tmo;
                repeat (3) begin @(posedge clk); #1; end
                d_q.push_back('{addr: 32'h2000_0100, we: 1'b0, wdata: 32'h0,
                                rdata: initval(32'h2000_0100)});
                bus.d_addr_i = 32'h2000_0100;
                bus.d_we_i   = 1'b0;
                bus.d_req_i  = 1'b1;
                snap = d_gn;
                tmo  = 0;
                while (d_gn == snap && tmo < 20) begin
                    @(posedge clk); #1;
                    tmo++;
                end
                if (d_gn == snap) fail_evt(g, "rst_test_grant");
                rst         = 1'b1;
                bus.d_req_i = 1'b0;
                @(posedge clk); #1;
                rst = 1'b0;
                d_q.delete();
                repeat (L + 4) begin @(posedge clk); #1; end
            end
            done_f = 1'b1;
        end
    end

    initial begin
        fork
            wait (cfg[0].done_f && cfg[1].done_f);
            begin
                #500000;
                chks++;
                errs++;
                $display("FAIL global_timeout: got unfinished run, expected completion");
            end
        join_any
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
